status_led_bank: RTL and testbench

Parametrised front-panel status indicator engine for board top levels. It takes N_CH raw status bits (PLL lock, auto-negotiation done, local-bus strobes, and so on) and drives one LED per channel. Each channel has its own compile-time mode: registered level, pulse stretch, shared heartbeat, or blink code. It replaces ad-hoc heartbeat counters and unstretched single-cycle strobes in each top level with one registered, reset-clean block in the `lb_clk` domain.

---
 rtl/status_led_bank_pkg.sv | 18 +
 rtl/status_led_chan.sv | 110 +++++++++++
 rtl/status_led_bank.sv | 77 +++++++
 tb/tb_status_led_bank.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/status_led_bank_pkg.sv
// status_led_bank_pkg: shared constants for the status LED bank.
//   - LED_MODE_* : per-channel mode encodings (2 bits each in MODES)
//   - blink_state_t : blink-code FSM states (LOAD is the reset state)
package status_led_bank_pkg;

  localparam logic [1:0] LED_MODE_LEVEL     = 2'd0;
  localparam logic [1:0] LED_MODE_STRETCH   = 2'd1;
  localparam logic [1:0] LED_MODE_HEARTBEAT = 2'd2;
  localparam logic [1:0] LED_MODE_BLINK     = 2'd3;

  typedef enum logic [1:0] {
    BL_LOAD = 2'd0,
    BL_ON   = 2'd1,
    BL_OFF  = 2'd2,
    BL_DARK = 2'd3
  } blink_state_t;

endpackage

// File: rtl/status_led_chan.sv
// status_led_chan: one LED channel of status_led_bank.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   tick       : prescaler event, high in the cycle the shared state advances
//   hb         : heartbeat value the top will hold after this edge
//   status     : raw status bit
//   code       : blink count (BLINK mode only, sampled in LOAD)
//   led_raw    : value the top registers into led at this edge
// led_raw is the LED value for the *next* cycle, so the top's output flop
// and this channel's state flops change together (blink/heartbeat edges
// line up with the registered tick output).
module status_led_chan
  import status_led_bank_pkg::*;
#(
  parameter logic [1:0] MODE    = LED_MODE_LEVEL,
  parameter int          STRETCH = 8,
  parameter int          GAP     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       hb,
  input  logic       status,
  input  logic [2:0] code,
  output logic       led_raw
);

  localparam logic [7:0] STRETCH_V = 8'(STRETCH);
  localparam logic [7:0] GAP_V     = 8'(GAP);
  localparam logic [7:0] GAP_M1    = 8'(GAP - 1);

  // Pulse stretch: reload beats a coincident tick decrement.
  logic [7:0] r_sc;
  always_ff @(posedge clk) begin
    if (reset)                       r_sc <= '0;
    else if (status)                 r_sc <= STRETCH_V;
    else if (tick && r_sc != 8'd0)   r_sc <= r_sc - 8'd1;
  end

  // Blink-code FSM.
  blink_state_t r_state, w_state_nxt;
  logic [2:0]   r_remain, w_remain_nxt;
  logic [7:0]   r_dcnt, w_dcnt_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= BL_LOAD;
      r_remain <= '0;
      r_dcnt   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_remain <= w_remain_nxt;
      r_dcnt   <= w_dcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_remain_nxt = r_remain;
    w_dcnt_nxt   = r_dcnt;
    if (tick) begin
      case (r_state)
        BL_LOAD: begin
          w_remain_nxt = code;
          if (code == 3'd0) begin
            w_state_nxt = BL_DARK;
            w_dcnt_nxt  = GAP_V;
          end else begin
            w_state_nxt = BL_ON;
          end
        end
        BL_ON: begin
          w_remain_nxt = r_remain - 3'd1;
          w_state_nxt  = BL_OFF;
        end
        BL_OFF: begin
          if (r_remain != 3'd0) begin
            w_state_nxt = BL_ON;
          end else begin
            // The final OFF tick counts toward the gap, hence GAP-1.
            w_state_nxt = BL_DARK;
            w_dcnt_nxt  = GAP_M1;
          end
        end
        BL_DARK: begin
          // <=1 also catches a zero count (GAP=1) so DARK never stalls.
          if (r_dcnt <= 8'd1) begin
            w_dcnt_nxt  = 8'd0;
            w_state_nxt = BL_LOAD;
          end else begin
            w_dcnt_nxt  = r_dcnt - 8'd1;
          end
        end
        default: w_state_nxt = BL_LOAD;
      endcase
    end
  end

  // All mode logic exists; MODE is constant so unused paths fold away.
  always_comb begin
    led_raw = 1'b0;
    case (MODE)
      LED_MODE_LEVEL:     led_raw = status;
      LED_MODE_STRETCH:   led_raw = status | (r_sc != 8'd0);
      LED_MODE_HEARTBEAT: led_raw = hb;
      default:            led_raw = (w_state_nxt == BL_ON);
    endcase
  end

endmodule

// File: rtl/status_led_bank.sv
// status_led_bank: front-panel status LED engine, one LED per channel.
// Ports:
//   clk, reset : single clock, synchronous active-high reset
//   status     : raw status bits [N_CH]
//   code       : blink counts, channel i at [3i+2:3i]
//   lamp_test  : forces all LEDs on (registered)
//   led        : registered LED drive [N_CH]
//   tick       : registered one-cycle prescaler strobe, period 2^PRESCALE_W
module status_led_bank
  import status_led_bank_pkg::*;
#(
  parameter int                N_CH       = 4,
  parameter int                PRESCALE_W = 22,
  parameter int                STRETCH    = 8,
  parameter int                GAP        = 4,
  parameter logic [2*N_CH-1:0] MODES      = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_CH-1:0]   status,
  input  logic [3*N_CH-1:0] code,
  input  logic              lamp_test,
  output logic [N_CH-1:0]   led,
  output logic              tick
);

  // One below all-ones: r_wrap is registered from this compare so it is
  // high exactly while r_pre is all-ones, keeping the wide compare off
  // the path into the channel logic.
  localparam logic [PRESCALE_W-1:0] PRE_WRAP_M1 = ~PRESCALE_W'(1);

  logic [PRESCALE_W-1:0] r_pre;
  logic                  r_wrap;
  logic                  r_tick;
  logic                  r_hb;
  logic                  w_hb_nxt;
  logic [N_CH-1:0]       w_led_raw;
  logic [N_CH-1:0]       r_led;

  assign w_hb_nxt = r_hb ^ r_wrap;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pre  <= '0;
      r_wrap <= 1'b0;
      r_tick <= 1'b0;
      r_hb   <= 1'b0;
      r_led  <= '0;
    end else begin
      r_pre  <= r_pre + PRESCALE_W'(1);
      r_wrap <= (r_pre == PRE_WRAP_M1);
      r_tick <= r_wrap;
      r_hb   <= w_hb_nxt;
      r_led  <= lamp_test ? '1 : w_led_raw;
    end
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    status_led_chan #(
      .MODE    (MODES[2*gi +: 2]),
      .STRETCH (STRETCH),
      .GAP     (GAP)
    ) u_chan (
      .clk     (clk),
      .reset   (reset),
      .tick    (r_wrap),
      .hb      (w_hb_nxt),
      .status  (status[gi]),
      .code    (code[3*gi +: 3]),
      .led_raw (w_led_raw[gi])
    );
  end

  assign led  = r_led;
  assign tick = r_tick;

endmodule

// File: tb/tb_status_led_bank.sv
module tb_status_led_bank;

  localparam int N  = 4;
  localparam int PW = 4;
  localparam int ST = 3;
  localparam int GP = 4;
  localparam int PERIOD = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  status;
  logic [3*N-1:0] code;
  logic          lamp_test;
  logic [N-1:0]  led;
  logic          tick;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int         m_cyc  = 0;   // non-reset edges since last reset
  int         m_last = -1;  // edge index of last status[1]=1
  bit         m_bl   = 1'b0;
  bit         m_q[$];       // remaining per-tick blink values of current frame
  logic [N-1:0] exp_led  = '0;
  logic         exp_tick = 1'b0;

  status_led_bank #(
    .N_CH(N), .PRESCALE_W(PW), .STRETCH(ST), .GAP(GP),
    .MODES({2'd3, 2'd2, 2'd1, 2'd0})
  ) dut (
    .clk(clk), .reset(reset), .status(status), .code(code),
    .lamp_test(lamp_test), .led(led), .tick(tick)
  );

  always #5 clk = ~clk;

  // Expected outputs after one clock edge, from the behavioural rules.
  task automatic model_edge();
    int k, c;
    bit tk, hb, alive, l1;
    if (reset) begin
      m_cyc = 0; m_last = -1; m_q.delete(); m_bl = 1'b0;
      exp_led = '0; exp_tick = 1'b0;
    end else begin
      m_cyc++;
      k  = m_cyc;
      tk = (k % PERIOD) == 0;
      hb = ((k / PERIOD) % 2) == 1;
      // Stretch still lit if fewer than ST ticks since last strobe.
      alive = (m_last >= 0) && (((k - 1) / PERIOD - m_last / PERIOD) < ST);
      l1 = status[1] | alive;
      if (status[1]) m_last = k;
      if (tk) begin
        if (m_q.size() == 0) begin
          c = int'(code[11:9]);
          if (c == 0) begin
            for (int i = 0; i < GP + 1; i++) m_q.push_back(1'b0);
          end else begin
            for (int i = 0; i < c; i++) begin m_q.push_back(1'b1); m_q.push_back(1'b0); end
            for (int i = 0; i < GP; i++) m_q.push_back(1'b0);
          end
        end
        m_bl = m_q.pop_front();
      end
      exp_tick = tk;
      exp_led  = lamp_test ? 4'hF : {m_bl, hb, l1, status[0]};
    end
  endtask

  task automatic chk(string tag, logic [N-1:0] got, logic [N-1:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s cyc=%0d got=%h exp=%h", tag, m_cyc, got, exp);
    end
  endtask

  task automatic chki(string tag, int got, int exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("led", led, exp_led);
    chk("tick", {3'b000, tick}, {3'b000, exp_tick});
  endtask

  initial begin
    int n;
    reset = 1'b1; status = '0; code = 12'h600; lamp_test = 1'b0;

    // Reset state
    repeat (3) cyc();
    chk("reset_led", led, 4'h0);
    reset = 1'b0;

    // First tick exactly one period after release, then periodic
    n = 0;
    do begin cyc(); n++; end while (tick !== 1'b1 && n < 40);
    chki("first_tick", n, PERIOD);
    n = 0;
    do begin cyc(); n++; end while (tick !== 1'b1 && n < 40);
    chki("tick_period", n, PERIOD);

    // LEVEL: 5-cycle pulse gives exactly 5 lit cycles
    repeat (3) cyc();
    n = 0;
    status[0] = 1'b1;
    repeat (5) begin cyc(); if (led[0]) n++; end
    status[0] = 1'b0;
    repeat (4) begin cyc(); if (led[0]) n++; end
    chki("level_width", n, 5);

    // STRETCH: single strobe, then a re-strobe while lit
    status[1] = 1'b1; cyc(); status[1] = 1'b0;
    repeat (70) cyc();
    status[1] = 1'b1; cyc(); status[1] = 1'b0;
    repeat (20) cyc();
    status[1] = 1'b1; cyc(); status[1] = 1'b0;
    repeat (80) cyc();

    // BLINK code 3, then change to 1 mid-frame
    repeat (170) cyc();
    repeat (37) cyc();
    code[11:9] = 3'd1;
    repeat (250) cyc();

    // BLINK code 0: dark once the current frame drains
    code[11:9] = 3'd0;
    repeat (200) cyc();
    n = 0;
    repeat (120) begin cyc(); if (led[3]) n++; end
    chki("blink_dark", n, 0);

    // lamp_test during a frame
    code[11:9] = 3'd3;
    repeat (120) cyc();
    lamp_test = 1'b1;
    cyc();
    chk("lamp_on", led, 4'hF);
    repeat (19) cyc();
    lamp_test = 1'b0;
    repeat (200) cyc();

    // Mid-operation reset during stretch and blink ON
    status[1] = 1'b1; cyc(); status[1] = 1'b0;
    n = 0;
    while (!m_bl && n < 400) begin cyc(); n++; end
    chki("found_blink_on", int'(m_bl), 1);
    reset = 1'b1;
    cyc();
    chk("midreset_led", led, 4'h0);
    reset = 1'b0;
    repeat (200) cyc();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      status    = 4'($urandom);
      status[1] = ($urandom_range(0, 20) == 0);
      lamp_test = ($urandom_range(0, 60) == 0);
      if ($urandom_range(0, 150) == 0) code = 12'($urandom);
      reset     = ($urandom_range(0, 600) == 0);
      cyc();
    end
    reset = 1'b0; lamp_test = 1'b0; status = '0;
    repeat (5) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
